// File: rtl/femto_mem_arbiter.sv
// rtl/femto_mem_arbiter.sv - two-requester (ifetch/data) arbiter for a single shared memory port
module femto_mem_arbiter #(
  parameter int ADDR_W     = 24,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_wmask,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_wmask,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic              grant_d
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

  state_t     state;
  logic [3:0] streak;
  logic       pick_if;

  // Data normally wins; a waiting fetch wins once data has taken STREAK_MAX grants in a row
  always_comb begin
    pick_if = if_req && (!d_req || (streak == STREAK_MAX));
  end

  // Arbitration FSM: all outputs are registered and only change on state transitions
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      streak    <= 4'd0;
      rdata     <= 32'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_wmask <= 4'd0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      busy      <= 1'b0;
      grant_d   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            state   <= GRANT;
            mem_req <= 1'b1;
            busy    <= 1'b1;
            grant_d <= !pick_if;
            if (pick_if) begin
              mem_we    <= 1'b0;
              mem_wmask <= 4'd0;
              mem_addr  <= if_addr;
              mem_wdata <= 32'd0;
              streak    <= 4'd0;
            end else begin
              mem_we    <= d_we;
              mem_wmask <= d_wmask;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              // only count data grants that actually made a fetch wait
              if (if_req && (streak != STREAK_MAX)) begin
                streak <= streak + 4'd1;
              end
            end
          end
        end
        GRANT: begin
          if (mem_ack) begin
            rdata   <= mem_rdata;
            mem_req <= 1'b0;
            state   <= DONE;
            if_ack  <= !grant_d;
            d_ack   <= grant_d;
          end
        end
        DONE: begin
          if_ack <= 1'b0;
          d_ack  <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_femto_mem_arbiter.sv
// tb/tb_femto_mem_arbiter.sv - directed table-driven bench for femto_mem_arbiter
module tb_femto_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [23:0] if_addr;
  logic        if_ack;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_wmask;
  logic [23:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] rdata;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_wmask;
  logic [23:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        grant_d;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] model_rdata;

  typedef struct {
    logic        ir;
    logic [23:0] ia;
    logic        dr;
    logic        dwe;
    logic [3:0]  dm;
    logic [23:0] da;
    logic [31:0] dw;
    logic [31:0] mr;
    int          dly;
    logic        egd;
    logic [23:0] eaddr;
    logic        ewe;
    logic [3:0]  em;
    logic [31:0] ewd;
  } vec_t;

  vec_t vecs [6];

  femto_mem_arbiter #(.ADDR_W(24), .MAX_STREAK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_wmask   (d_wmask),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .rdata     (rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_wmask (mem_wmask),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .grant_d   (grant_d)
  );

  always #5 clk = ~clk;

  // both acks must never pulse together
  always @(negedge clk) begin
    if (!rst) begin
      n_cmp++;
      if (if_ack && d_ack) begin
        n_fail++;
        $display("FAIL dual_ack: if_ack=%0b d_ack=%0b required not both 1", if_ack, d_ack);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_if_ack"}, if_ack, 0);
    chk({tag, "_d_ack"}, d_ack, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_wmask"}, mem_wmask, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_grant_d"}, grant_d, 0);
  endtask

  // Called with the DUT in IDLE and requests already driven
  task automatic run_txn(input logic egd, input logic [23:0] eaddr, input logic ewe,
                         input logic [3:0] em, input logic [31:0] ewd, input logic [31:0] mr,
                         input int dly, input logic drop_if, input logic drop_d,
                         input logic disturb);
    int n;
    tick;
    n = 1;
    chk("latency_mem_req", mem_req, 1);
    while (!mem_req && n < 10) begin
      tick;
      n++;
    end
    if (!mem_req) return;
    chk("grant_d", grant_d, egd);
    chk("mem_addr", mem_addr, eaddr);
    chk("mem_we", mem_we, ewe);
    chk("mem_wmask", mem_wmask, em);
    chk("mem_wdata", mem_wdata, ewd);
    chk("busy_grant", busy, 1);
    for (int i = 0; i < dly; i++) begin
      if (disturb && i == 0) begin
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 24'h0003C0;
        d_wmask = 4'hC;
        d_wdata = 32'h5555AAAA;
      end
      tick;
      chk("wait_mem_req", mem_req, 1);
      chk("wait_mem_addr", mem_addr, eaddr);
      chk("wait_mem_we", mem_we, ewe);
      chk("wait_mem_wdata", mem_wdata, ewd);
      chk("wait_grant_d", grant_d, egd);
      chk("wait_busy", busy, 1);
      chk("wait_rdata_hold", rdata, model_rdata);
      chk("wait_no_ack", {if_ack, d_ack}, 0);
    end
    mem_ack   = 1'b1;
    mem_rdata = mr;
    tick;
    mem_ack = 1'b0;
    model_rdata = mr;
    chk("done_if_ack", if_ack, !egd);
    chk("done_d_ack", d_ack, egd);
    chk("done_mem_req", mem_req, 0);
    chk("done_rdata", rdata, model_rdata);
    chk("done_busy", busy, 1);
    if (drop_if) if_req = 1'b0;
    if (drop_d) d_req = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = ~mr;
    tick;
    mem_ack = 1'b0;
    chk("idle_acks", {if_ack, d_ack}, 0);
    chk("idle_busy", busy, 0);
    chk("idle_mem_req", mem_req, 0);
    chk("idle_rdata_hold", rdata, model_rdata);
  endtask

  initial begin
    vecs[0] = '{1'b1, 24'h000100, 1'b0, 1'b0, 4'h0, 24'h0, 32'h0, 32'hDEADBEEF, 0,
                1'b0, 24'h000100, 1'b0, 4'h0, 32'h0};
    vecs[1] = '{1'b0, 24'h0, 1'b1, 1'b1, 4'hF, 24'h000200, 32'h12345678, 32'h00000000, 1,
                1'b1, 24'h000200, 1'b1, 4'hF, 32'h12345678};
    vecs[2] = '{1'b0, 24'h0, 1'b1, 1'b0, 4'h0, 24'h000ABC, 32'h0, 32'hCAFEF00D, 2,
                1'b1, 24'h000ABC, 1'b0, 4'h0, 32'h0};
    vecs[3] = '{1'b1, 24'hFFFFFC, 1'b0, 1'b0, 4'h0, 24'h0, 32'h0, 32'h01234567, 0,
                1'b0, 24'hFFFFFC, 1'b0, 4'h0, 32'h0};
    vecs[4] = '{1'b0, 24'h0, 1'b1, 1'b1, 4'h5, 24'h800000, 32'hA5A5A5A5, 32'h11111111, 3,
                1'b1, 24'h800000, 1'b1, 4'h5, 32'hA5A5A5A5};
    vecs[5] = '{1'b1, 24'h000004, 1'b0, 1'b0, 4'h0, 24'h0, 32'h0, 32'hFFFFFFFF, 1,
                1'b0, 24'h000004, 1'b0, 4'h0, 32'h0};

    rst = 1'b1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_wmask = 0;
    d_addr = 0; d_wdata = 0; mem_ack = 0; mem_rdata = 0;
    model_rdata = 32'h0;
    tick;
    tick;
    chk_idle_zero("rst_hold");
    rst = 1'b0;
    tick;
    chk_idle_zero("post_rst");

    // single-requester vectors
    for (int k = 0; k < 6; k++) begin
      if_req = vecs[k].ir; if_addr = vecs[k].ia;
      d_req = vecs[k].dr; d_we = vecs[k].dwe; d_wmask = vecs[k].dm;
      d_addr = vecs[k].da; d_wdata = vecs[k].dw;
      run_txn(vecs[k].egd, vecs[k].eaddr, vecs[k].ewe, vecs[k].em, vecs[k].ewd,
              vecs[k].mr, vecs[k].dly, vecs[k].ir, vecs[k].dr, 1'b0);
    end

    // simultaneous requests: data first, then fetch
    if_req = 1; if_addr = 24'h000080;
    d_req = 1; d_we = 1; d_wmask = 4'hF; d_addr = 24'h000200; d_wdata = 32'h12345678;
    run_txn(1'b1, 24'h000200, 1'b1, 4'hF, 32'h12345678, 32'h0BADF00D, 0, 1'b0, 1'b1, 1'b0);
    run_txn(1'b0, 24'h000080, 1'b0, 4'h0, 32'h0, 32'h87654321, 0, 1'b1, 1'b0, 1'b0);

    // starvation bound: four data grants, then fetch, then data resumes
    if_req = 1; if_addr = 24'h000040;
    d_req = 1; d_we = 1; d_wmask = 4'h3; d_addr = 24'h000300; d_wdata = 32'hFEEDFACE;
    for (int k = 0; k < 4; k++) begin
      run_txn(1'b1, 24'h000300, 1'b1, 4'h3, 32'hFEEDFACE, 32'h100 + k, 0, 1'b0, 1'b0, 1'b0);
    end
    run_txn(1'b0, 24'h000040, 1'b0, 4'h0, 32'h0, 32'h00C0FFEE, 0, 1'b1, 1'b0, 1'b0);
    run_txn(1'b1, 24'h000300, 1'b1, 4'h3, 32'hFEEDFACE, 32'h00000200, 0, 1'b0, 1'b1, 1'b0);

    // wait states with a data request arriving mid-grant
    if_req = 1; if_addr = 24'h001000; d_req = 0;
    run_txn(1'b0, 24'h001000, 1'b0, 4'h0, 32'h0, 32'h13579BDF, 5, 1'b1, 1'b0, 1'b1);
    run_txn(1'b1, 24'h0003C0, 1'b1, 4'hC, 32'h5555AAAA, 32'h2468ACE0, 0, 1'b0, 1'b1, 1'b0);

    // reset in GRANT with streak at its limit
    if_req = 1; if_addr = 24'h000500;
    d_req = 1; d_we = 1; d_wmask = 4'hF; d_addr = 24'h000600; d_wdata = 32'h77778888;
    for (int k = 0; k < 3; k++) begin
      run_txn(1'b1, 24'h000600, 1'b1, 4'hF, 32'h77778888, 32'h300 + k, 0, 1'b0, 1'b0, 1'b0);
    end
    tick;
    chk("rst_txn_mem_req", mem_req, 1);
    tick;
    rst = 1'b1;
    tick;
    chk_idle_zero("mid_rst");
    rst = 1'b0; if_req = 0; d_req = 0;
    model_rdata = 32'h0;
    tick;
    chk_idle_zero("after_mid_rst");
    mem_ack = 1; mem_rdata = 32'hBADBAD00;
    tick;
    mem_ack = 0;
    chk("stray_rdata", rdata, 0);
    chk("stray_busy", busy, 0);
    chk("stray_mem_req", mem_req, 0);
    tick;
    chk("stray_acks", {if_ack, d_ack}, 0);
    if_req = 1; d_req = 1;
    run_txn(1'b1, 24'h000600, 1'b1, 4'hF, 32'h77778888, 32'h0000AAAA, 0, 1'b0, 1'b1, 1'b0);
    run_txn(1'b0, 24'h000500, 1'b0, 4'h0, 32'h0, 32'h0000BBBB, 0, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/femto_mem_arbiter.md
FEMTO_MEM_ARBITER -- requirements
Module: femto_mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 24, byte address width of the shared memory port.
REQ-002 Parameter: MAX_STREAK, 4, maximum consecutive data grants while ifetch waits; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 if_req  input  1  instruction-fetch read request; level, held until if_ack.
REQ-006 if_addr  input  ADDR_W  fetch address; stable while if_req=1.
REQ-007 if_ack  output  1  one-cycle pulse; fetch complete, rdata valid.
REQ-008 d_req  input  1  data-access request; level, held until d_ack.
REQ-009 d_we  input  1  1=write, 0=read; stable while d_req=1.
REQ-010 d_wmask  input  4  byte write enables; ignored on read.
REQ-011 d_addr  input  ADDR_W  data address; stable while d_req=1.
REQ-012 d_wdata  input  32  write data; stable while d_req=1.
REQ-013 d_ack  output  1  one-cycle pulse; data access complete.
REQ-014 rdata  output  32  registered read data, shared by both requesters.
REQ-015 mem_req  output  1  request to memory controller; level, held until mem_ack.
REQ-016 mem_we, mem_wmask, mem_addr, mem_wdata  output  1/4/ADDR_W/32  latched payload of the granted requester.
REQ-017 mem_ack  input  1  memory controller completion pulse; mem_rdata valid same cycle.
REQ-018 mem_rdata  input  32  memory read data.
REQ-019 busy  output  1  high in any state other than IDLE.
REQ-020 grant_d  output  1  1 when current/last grant is the data requester.

Function
REQ-021 FSM states SHALL be IDLE, GRANT, DONE.
REQ-022 IDLE: if if_req or d_req high at the clock edge, winner chosen, payload latched, next state GRANT; else stay IDLE.
REQ-023 Arbitration: d_req wins over if_req, except ifetch wins when if_req=1 and streak==MAX_STREAK.
REQ-024 streak counter (4 bit): +1 on each data grant made while if_req=1; saturates at MAX_STREAK; cleared on every ifetch grant; unchanged on data grant with if_req=0.
REQ-025 GRANT: mem_req=1 with latched payload (ifetch grant drives mem_we=0, mem_wmask=0, mem_wdata=0); on mem_ack=1 capture mem_rdata into rdata, next state DONE.
REQ-026 DONE: exactly one of if_ack/d_ack high for one cycle, matching the grant; mem_req=0; next state IDLE unconditionally.
REQ-027 rdata SHALL hold its value until the next mem_ack in GRANT; on data writes rdata is updated with mem_rdata regardless (value don't-care to requester).
REQ-028 Latency: request sampled in IDLE at cycle 0 -> mem_req high cycle 1 -> mem_ack in cycle k>=1 -> ack in cycle k+1 -> IDLE cycle k+2; minimum 3 cycles request-to-ack-end.
REQ-029 Requesters SHALL drop req in the cycle after ack; arbiter samples requests only in IDLE.
REQ-030 mem_ack in IDLE or DONE SHALL be ignored (no state, rdata or ack change).
REQ-031 Requests changing while in GRANT/DONE SHALL NOT alter the latched payload or grant.
REQ-032 if_ack and d_ack SHALL never be high in the same cycle.

Reset
REQ-033 rst=1 at a clock edge: state IDLE, streak=0, rdata=0, latched payload=0, grant_d=0.
REQ-034 During and after reset: mem_req=0, if_ack=0, d_ack=0, busy=0; mem_we/mem_wmask/mem_addr/mem_wdata=0.
REQ-035 Reset mid-transaction SHALL abandon it: mem_req low the cycle after the reset edge, no ack pulse issued.

Verification
REQ-036 Single fetch: if_req, if_addr=0x000100, mem_ack in first GRANT cycle, mem_rdata=0xDEADBEEF -> mem_addr=0x000100, if_ack at cycle 2, rdata=0xDEADBEEF.
REQ-037 Simultaneous: if_req and d_req (write, d_addr=0x000200, wmask=0xF, wdata=0x12345678) same cycle -> data granted first with mem_we=1, then fetch granted.
REQ-038 Starvation: d_req held continuously, if_req held, MAX_STREAK=4 -> exactly 4 d_ack pulses, then if_ack, then data resumes.
REQ-039 Wait states: mem_ack delayed 5 cycles -> mem_req and payload stable for 5 cycles, ack 1 cycle after mem_ack, busy high throughout.
REQ-040 Reset in GRANT: assert rst 2 cycles into a data write -> mem_req=0 next cycle, no d_ack, streak=0; later stray mem_ack in IDLE ignored.
